// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS32-subset core: opcode/funct
// values, the ALU operation set and the control FSM states.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_BREAK = 6'h0D;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU. Shifts take their amount from a[4:0] and shift b,
// so the core routes shamt or rs into a for the shift instructions.
module mips_alu
    import mips_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    // Select the operation result; compares produce a zero-extended 0/1
    always_comb begin
        result = 32'h0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SLT:  result = {31'h0, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {31'h0, (a < b)};
            ALU_SLL:  result = b << a[4:0];
            ALU_SRL:  result = b >> a[4:0];
            ALU_SRA:  result = $unsigned($signed(b) >>> a[4:0]);
            ALU_LUI:  result = {b[15:0], 16'h0};
            default:  result = 32'h0;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS32-subset core with valid/ack instruction and data ports,
// hardwired r0, illegal-opcode trap and a retire trace port.
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int          NREGS    = 32,
    parameter int          IADDR_W  = 8,
    parameter int          DADDR_W  = 7,
    parameter logic [31:0] PC_RESET = 32'h0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IADDR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ack,
    input  logic [31:0]        dmem_rdata,
    output logic               retire,
    output logic [31:0]        retire_pc,
    output logic               halted,
    output logic               illegal
);

    localparam int RW = $clog2(NREGS);

    state_e                     state;
    logic [31:0]                pc, ir, a_reg, b_reg, alu_out, mdr, npc;
    logic [NREGS-1:0][31:0]     regs;

    logic [5:0]    opcode, funct;
    logic [4:0]    shamt;
    logic [RW-1:0] rs_idx, rt_idx, rd_idx, dest;
    logic [31:0]   imm_sext, imm_zext, src_a, src_b, alu_result, wb_data;
    logic [31:0]   pc_plus4, br_target, j_target;
    logic          alu_zero, reg_write, is_lw, is_sw, is_beq, is_bne, is_j;
    logic          is_break, is_illegal, taken;
    alu_op_e       alu_op;

    assign opcode   = ir[31:26];
    assign funct    = ir[5:0];
    assign shamt    = ir[10:6];
    assign rs_idx   = ir[21 +: RW];
    assign rt_idx   = ir[16 +: RW];
    assign rd_idx   = ir[11 +: RW];
    assign imm_sext = {{16{ir[15]}}, ir[15:0]};
    assign imm_zext = {16'h0, ir[15:0]};

    assign imem_addr = pc[IADDR_W+1:2];

    // Decode the latched instruction into ALU operands and control flags
    always_comb begin
        alu_op     = ALU_ADD;
        src_a      = a_reg;
        src_b      = b_reg;
        dest       = rd_idx;
        reg_write  = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_break   = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_write = 1'b1;
                case (funct)
                    FN_SLL:   begin alu_op = ALU_SLL; src_a = {27'h0, shamt}; end
                    FN_SRL:   begin alu_op = ALU_SRL; src_a = {27'h0, shamt}; end
                    FN_SRA:   begin alu_op = ALU_SRA; src_a = {27'h0, shamt}; end
                    FN_SLLV:  alu_op = ALU_SLL;
                    FN_SRLV:  alu_op = ALU_SRL;
                    FN_SRAV:  alu_op = ALU_SRA;
                    FN_ADD:   alu_op = ALU_ADD;
                    FN_SUB:   alu_op = ALU_SUB;
                    FN_AND:   alu_op = ALU_AND;
                    FN_OR:    alu_op = ALU_OR;
                    FN_XOR:   alu_op = ALU_XOR;
                    FN_NOR:   alu_op = ALU_NOR;
                    FN_SLT:   alu_op = ALU_SLT;
                    FN_SLTU:  alu_op = ALU_SLTU;
                    FN_BREAK: begin reg_write = 1'b0; is_break = 1'b1; end
                    default:  begin reg_write = 1'b0; is_illegal = 1'b1; end
                endcase
            end
            OP_J:    is_j = 1'b1;
            OP_BEQ:  begin alu_op = ALU_SUB; is_beq = 1'b1; end
            OP_BNE:  begin alu_op = ALU_SUB; is_bne = 1'b1; end
            OP_ADDI: begin src_b = imm_sext; dest = rt_idx; reg_write = 1'b1; end
            OP_SLTI: begin alu_op = ALU_SLT; src_b = imm_sext; dest = rt_idx; reg_write = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; src_b = imm_zext; dest = rt_idx; reg_write = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  src_b = imm_zext; dest = rt_idx; reg_write = 1'b1; end
            OP_XORI: begin alu_op = ALU_XOR; src_b = imm_zext; dest = rt_idx; reg_write = 1'b1; end
            OP_LUI:  begin alu_op = ALU_LUI; src_b = imm_zext; dest = rt_idx; reg_write = 1'b1; end
            OP_LW:   begin src_b = imm_sext; dest = rt_idx; reg_write = 1'b1; is_lw = 1'b1; end
            OP_SW:   begin src_b = imm_sext; is_sw = 1'b1; end
            default: is_illegal = 1'b1;
        endcase
    end

    mips_alu u_alu (
        .op     (alu_op),
        .a      (src_a),
        .b      (src_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign taken     = (is_beq & alu_zero) | (is_bne & ~alu_zero);
    assign wb_data   = is_lw ? mdr : alu_out;

    // Control FSM, register file and all registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= PC_RESET;
            npc        <= PC_RESET;
            ir         <= 32'h0;
            a_reg      <= 32'h0;
            b_reg      <= 32'h0;
            alu_out    <= 32'h0;
            mdr        <= 32'h0;
            regs       <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= 32'h0;
            retire     <= 1'b0;
            retire_pc  <= 32'h0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH: begin
                    imem_req <= 1'b1;
                    if (imem_req && imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_reg <= regs[rs_idx];
                    b_reg <= regs[rt_idx];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_out <= alu_result;
                    npc     <= is_j ? j_target : (taken ? br_target : pc_plus4);
                    if (is_break || is_illegal) begin
                        halted  <= 1'b1;
                        illegal <= is_illegal;
                        state   <= S_HALT;
                    end else if (is_lw || is_sw) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_sw;
                        dmem_addr  <= alu_result[DADDR_W+1:2];
                        dmem_wdata <= b_reg;
                        state      <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (!dmem_we) mdr <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= S_WB;
                    end
                end
                S_WB: begin
                    if (reg_write && dest != '0) regs[dest] <= wb_data;
                    pc        <= npc;
                    retire    <= 1'b1;
                    retire_pc <= pc;
                    imem_req  <= 1'b1;
                    state     <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
